ascii_cmd_parser: RTL
=====================

Name: ascii_cmd_parser

Overview:
- Receives an ASCII byte stream from the UART receiver and decodes line-based host commands for the AES verify platform.
- Holds the registered control and data words that feed the stimulus generator: 128-bit key, 128-bit text/seed, enc/dec mode, work enable, and counter clear.
- Forms the host→board direction of the serial link that the ASCII status reporter uses for board→host.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- TIMEOUT_MS, 100, maximum gap between bytes inside a partial line before that line is aborted.
- TIMEOUT_COUNT (localparam), CLK_FREQ/1000*TIMEOUT_MS, timeout in cycles; the counter width is the clog2 of this value.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- data  in  8  received byte, qualified by valid.
- valid  in  1  one-cycle strobe per received byte; the parser accepts every byte and has no backpressure.
- key  out  128  committed key.
- text  out  128  committed plaintext/seed.
- enc  out  1  1=encrypt, 0=decrypt.
- work  out  1  run enable for the generator and checker.
- load_key  out  1  one-cycle pulse when key updates.
- load_text  out  1  one-cycle pulse when text updates.
- clear  out  1  one-cycle pulse requesting total/correct counters reset.
- cmd_err  out  1  one-cycle pulse on any rejected line.
- err_count  out  8  saturating count of rejected lines.

Behaviour:
- Reset values: key=0, text=0, enc=1, work=0, all pulses 0, err_count=0, FSM=IDLE, nibble count 0, timeout counter 0.
- Hex decode: '0'-'9', 'A'-'F' and 'a'-'f' map to a nibble. All other characters are non-hex.
- Terminators: CR (0x0D) and LF (0x0A).
- FSM states: IDLE, HEX, EOL, FLUSH.
- IDLE:
  - Terminators and space are ignored, so blank lines and CRLF/LFCR pairs are harmless.
  - 'K' or 'T' latches the target, clears the shift register and nibble count, and goes to HEX.
  - 'E', 'D', 'S', 'H' and 'R' latch the opcode and go to EOL.
  - Any other byte raises an error and goes to FLUSH.
- HEX:
  - A hex byte shifts in: shreg <= {shreg[123:0], nib}; count+1.
  - A terminator with count==32 commits the shreg to key or text, asserts load_key or load_text, and goes to IDLE.
  - A terminator with count<32 raises an error and goes to IDLE; no output changes.
  - A 33rd hex digit, or any non-hex non-terminator byte, raises an error and goes to FLUSH.
- EOL:
  - A terminator executes the opcode and goes to IDLE:
    - E: enc=1.
    - D: enc=0.
    - S: work=1.
    - H: work=0.
    - R: clear pulse.
  - Any other byte raises an error and goes to FLUSH.
- FLUSH: bytes are discarded until a terminator, then the FSM goes to IDLE. No second error is raised for the same line.
- Error handling: cmd_err pulses for one cycle and err_count increments, saturating at 255. The error pulse and count update fire on the transition out of the faulting state; they do not fire again on FLUSH exit.
- Latency: every output update and pulse is registered. It becomes visible on the first clk edge after the edge that samples the terminating byte, i.e. 1 cycle after valid.
- Timeout:
  - In HEX, EOL or FLUSH, the counter increments every cycle with no valid and resets on valid.
  - Reaching TIMEOUT_COUNT forces IDLE. In HEX or EOL this raises an error; in FLUSH the return is silent. No outputs change.
  - In IDLE the counter is held at 0.
- Simultaneous events: a valid byte in the same cycle the timeout count is reached takes priority; the byte is processed and the counter resets.
- Pulses: at most one of load_key, load_text, clear and cmd_err is asserted per cycle, by construction.
- Reset mid-line: the partial shreg is discarded and all outputs return to their reset values immediately (asynchronous).
- Decoupling: key and text stay stable between loads; the shreg is internal and never drives outputs directly.

Decomposition:
- Shared package: ASCII constants (CR, LF, SPACE, command letters), FSM state encodings, the hex_to_nibble function, and the clog2 function.
- Submodule: one natural split, ascii_hex_decode (byte → {is_hex, nibble}). It is combinational and is reusable by other ASCII front ends.

Test Plan:
- "K000102030405060708090A0B0C0D0E0F\r" → key=128'h000102030405060708090a0b0c0d0e0f one cycle after the CR; load_key pulses exactly once; text unchanged.
- "t00112233445566778899aabbccddeeff\n\r" (lowercase command letter and hex) → text=128'h00112233445566778899AABBCCDDEEFF; load_text pulses once; the trailing CR is ignored with no cmd_err.
- "S\r", "D\r", "R\r" in sequence → work=1, then enc=0, then one clear pulse; err_count stays 0.
- "K0123\r" (short), then "K" followed by 33 hex digits and "\r", then "Zxyz\r" → three cmd_err pulses; err_count=3; key still 0.
- "K01" followed by silence for TIMEOUT_COUNT cycles (bench TIMEOUT_MS=1, CLK_FREQ=100_000) → cmd_err pulse and return to IDLE. A following "E\r" sets enc=1 and is parsed normally.
- Assert rst_n low after "K0011" and mid-byte stream → all outputs return to reset values. A full K line after reset release loads correctly, with no stale nibbles in the shreg.

Source files
------------

// File: rtl/ascii_cmd_parser_pkg.sv
// Shared definitions for the ASCII host-command parser: character codes,
// FSM encoding, hex decode and clog2 helpers.
`default_nettype none

package ascii_cmd_parser_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] CMD_KEY     = 8'h4B;  // 'K'
  localparam logic [7:0] CMD_TEXT    = 8'h54;  // 'T'
  localparam logic [7:0] CMD_ENC     = 8'h45;  // 'E'
  localparam logic [7:0] CMD_DEC     = 8'h44;  // 'D'
  localparam logic [7:0] CMD_START   = 8'h53;  // 'S'
  localparam logic [7:0] CMD_HALT    = 8'h48;  // 'H'
  localparam logic [7:0] CMD_RESET   = 8'h52;  // 'R'

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HEX   = 2'd1,
    ST_EOL   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Returns {is_hex, nibble}; nibble is 0 for non-hex characters.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascii_cmd_parser_hex.sv
// Combinational ASCII hex-digit decoder, reusable by other ASCII front ends.
`default_nettype none

module ascii_hex_decode
  import ascii_cmd_parser_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  logic [4:0] dec_w;

  assign dec_w    = hex_to_nibble(char_i);
  assign is_hex_o = dec_w[4];
  assign nibble_o = dec_w[3:0];

endmodule

`default_nettype wire

// File: rtl/ascii_cmd_parser.sv
// Line-based host command parser: decodes K/T hex loads and E/D/S/H/R
// opcodes into registered control words for the AES stimulus generator.
`default_nettype none

module ascii_cmd_parser
  import ascii_cmd_parser_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TIMEOUT_MS = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   data,
  input  logic         valid,
  output logic [127:0] key,
  output logic [127:0] text,
  output logic         enc,
  output logic         work,
  output logic         load_key,
  output logic         load_text,
  output logic         clear,
  output logic         cmd_err,
  output logic [7:0]   err_count
);

  localparam int TIMEOUT_COUNT = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int TW_RAW        = clog2(TIMEOUT_COUNT);
  localparam int TW            = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_COUNT - 1);

  state_t         state_q, state_d;
  logic [127:0]   shreg_q, shreg_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           tgt_text_q, tgt_text_d;
  logic [7:0]     op_q, op_d;
  logic [127:0]   key_q, key_d, text_q, text_d;
  logic           enc_q, enc_d, work_q, work_d;
  logic           load_key_q, load_key_d, load_text_q, load_text_d;
  logic           clear_q, clear_d, cmd_err_q, cmd_err_d;
  logic [7:0]     err_count_q, err_count_d;

  logic           is_hex_w;
  logic [3:0]     nib_w;
  logic           is_term_w;
  logic [7:0]     letter_w;
  logic           tmo_hit_w;
  logic           err_w;

  ascii_hex_decode u_hex (
    .char_i   (data),
    .is_hex_o (is_hex_w),
    .nibble_o (nib_w)
  );

  assign is_term_w = (data == ASCII_CR) || (data == ASCII_LF);
  // Command letters are case-insensitive.
  assign letter_w  = (data >= 8'h61 && data <= 8'h7A) ? (data & 8'hDF) : data;
  assign tmo_hit_w = !valid && (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    tgt_text_d  = tgt_text_q;
    op_d        = op_q;
    key_d       = key_q;
    text_d      = text_q;
    enc_d       = enc_q;
    work_d      = work_q;
    load_key_d  = 1'b0;
    load_text_d = 1'b0;
    clear_d     = 1'b0;
    err_w       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (valid && !is_term_w && data != ASCII_SPACE) begin
          if (letter_w == CMD_KEY || letter_w == CMD_TEXT) begin
            tgt_text_d = (letter_w == CMD_TEXT);
            shreg_d    = '0;
            cnt_d      = '0;
            state_d    = ST_HEX;
          end else if (letter_w == CMD_ENC || letter_w == CMD_DEC ||
                       letter_w == CMD_START || letter_w == CMD_HALT ||
                       letter_w == CMD_RESET) begin
            op_d    = letter_w;
            state_d = ST_EOL;
          end else begin
            err_w   = 1'b1;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_HEX: begin
        if (valid) begin
          if (is_hex_w && cnt_q != 6'd32) begin
            shreg_d = {shreg_q[123:0], nib_w};
            cnt_d   = cnt_q + 6'd1;
          end else if (is_term_w) begin
            state_d = ST_IDLE;
            if (cnt_q == 6'd32) begin
              if (tgt_text_q) begin
                text_d      = shreg_q;
                load_text_d = 1'b1;
              end else begin
                key_d      = shreg_q;
                load_key_d = 1'b1;
              end
            end else begin
              err_w = 1'b1;
            end
          end else begin
            err_w   = 1'b1;
            state_d = ST_FLUSH;
          end
        end else if (tmo_hit_w) begin
          err_w   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EOL: begin
        if (valid) begin
          if (is_term_w) begin
            state_d = ST_IDLE;
            if (op_q == CMD_ENC)   enc_d   = 1'b1;
            if (op_q == CMD_DEC)   enc_d   = 1'b0;
            if (op_q == CMD_START) work_d  = 1'b1;
            if (op_q == CMD_HALT)  work_d  = 1'b0;
            if (op_q == CMD_RESET) clear_d = 1'b1;
          end else begin
            err_w   = 1'b1;
            state_d = ST_FLUSH;
          end
        end else if (tmo_hit_w) begin
          err_w   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if ((valid && is_term_w) || tmo_hit_w) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_err_d   = err_w;
    err_count_d = (err_w && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;

    // Idle gap counter only runs while a line is partially received.
    if (state_d == ST_IDLE || state_q == ST_IDLE || valid) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      tgt_text_q  <= 1'b0;
      op_q        <= '0;
      key_q       <= '0;
      text_q      <= '0;
      enc_q       <= 1'b1;
      work_q      <= 1'b0;
      load_key_q  <= 1'b0;
      load_text_q <= 1'b0;
      clear_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      tgt_text_q  <= tgt_text_d;
      op_q        <= op_d;
      key_q       <= key_d;
      text_q      <= text_d;
      enc_q       <= enc_d;
      work_q      <= work_d;
      load_key_q  <= load_key_d;
      load_text_q <= load_text_d;
      clear_q     <= clear_d;
      cmd_err_q   <= cmd_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign key       = key_q;
  assign text      = text_q;
  assign enc       = enc_q;
  assign work      = work_q;
  assign load_key  = load_key_q;
  assign load_text = load_text_q;
  assign clear     = clear_q;
  assign cmd_err   = cmd_err_q;
  assign err_count = err_count_q;

endmodule

`default_nettype wire
